ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the SoC bus side to the keyboard over the open-collector ps2_clk/ps2_data pair. It is the transmit counterpart of the existing PS/2 receiver and shares the same two pins. It performs the inhibit/request-to-send sequence, shifts bits on device-generated clock edges, checks the device acknowledge and reports completion or error. The receiver must ignore the lines while `busy` is high.

## Interface
Parameters:
- INHIBIT_CYCLES, 10000, system clocks ps2_clk is held low before request (100 µs at 100 MHz)
- TIMEOUT_CYCLES, 2000000, max system clocks waiting for any single device edge or bus release (20 ms)

Ports:
- clk  in  1  system clock; the block uses this single clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE and not in reset
- busy  out  1  high from accept until done pulse
- done  out  1  one-cycle completion pulse
- err  out  2  valid with done: 0 ok, 1 no ack, 2 timeout
- ps2_clk_i  in  1  raw pin level (asynchronous)
- ps2_data_i  in  1  raw pin level (asynchronous)
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release

## Operation
- Inputs pass through 2-FF synchronizers; fall = prev & ~cur on the synchronized clock.
- On accept, the byte is latched with odd parity p = ~^tx_data. Shift frame = {stop 1, p, d7..d0}.
- IDLE -> INHIBIT: clk_oe=1, counter loads INHIBIT_CYCLES.
- INHIBIT -> REQ at counter end: data_oe=1 (start bit 0) and clk_oe=0 in the same cycle.
- REQ/SHIFT: on each fall, drive the next frame bit (data_oe = ~bit). Falls 1..8 carry d0..d7, fall 9 carries parity, fall 10 carries stop (data released).
- ACK: at fall 11, sample data. 0 = acknowledged; 1 = err 1.
- WAIT_IDLE: wait until both synchronized lines are high, then DONE (done=1 for one cycle) -> IDLE.
- Timeout counter reloads on every fall. If it expires in REQ, SHIFT, ACK or WAIT_IDLE: release both lines, done=1, err=2, go to IDLE.
- An err=1 transfer still passes through WAIT_IDLE before done.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, done=0, err=0, busy=0. tx_ready=0 while rst=1, and 1 on the first cycle after.
- Accept at cycle T: busy=1 and clk_oe=1 at T+1. clk_oe stays high for exactly INHIBIT_CYCLES cycles. data_oe rises the cycle clk_oe falls.
- Pin fall to data_oe update: 3 clk cycles (2 sync + edge register).
- tx_valid while not ready is ignored; no queuing.
- rst mid-transfer: both oe low next cycle, no done pulse, frame discarded.
- Glitch-free outputs: oe signals are registered, never combinational.
- Counters are $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1) bits wide. Bit index is 4 bits, 0..11.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE)
  - the err codes (PS2_OK, PS2_NOACK, PS2_TIMEOUT)
  - the odd-parity function, shared with the receiver
- One sub-module, ps2_line_sync: 2-FF sync plus falling-edge detect for clk and data. It is reused by the receiver.

## Test plan
- Device model sends 0xED with ack, bit period 80 µs. Required: sampled bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1; done with err=0; busy low after done.
- Send 0xF4 (five 1s). Required: parity bit 0, err=0. Also check clk_oe high for exactly INHIBIT_CYCLES (set to 50 in sim).
- Device model never acks (data high at fall 11). Required: done with err=1 only after both lines read high.
- Device model stops clocking after 4 falls, with TIMEOUT_CYCLES=1000. Required: 1000 cycles after the last fall, both oe=0, done=1, err=2.
- Assert rst during SHIFT. Required: oe low the next cycle, no done, tx_ready=1 after reset; a following 0xED transfer completes with err=0.
- Pulse tx_valid while busy. Required: ignored; exactly one frame is sent.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_state_e;

  typedef enum logic [1:0] {
    PS2_OK      = 2'd0,
    PS2_NOACK   = 2'd1,
    PS2_TIMEOUT = 2'd2
  } ps2_err_e;

  // Fall on which the stop bit goes out; the next fall is the device acknowledge.
  localparam logic [3:0] PS2_STOP_FALL = 4'd10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pins, plus
// falling-edge detect on each synchronized line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o,
  output logic data_fall_o
);

  logic [1:0] clk_meta_q;
  logic [1:0] data_meta_q;
  logic       clk_prev_q;
  logic       data_prev_q;

  // Idle bus level is high; resetting to 1 avoids a false fall after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      data_prev_q <= 1'b1;
    end else begin
      clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
      data_meta_q <= {data_meta_q[0], ps2_data_i};
      clk_prev_q  <= clk_meta_q[1];
      data_prev_q <= data_meta_q[1];
    end
  end

  assign clk_s_o     = clk_meta_q[1];
  assign data_s_o    = data_meta_q[1];
  assign clk_fall_o  = clk_prev_q & ~clk_meta_q[1];
  assign data_fall_o = data_prev_q & ~data_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte
// on device clock falls, check the acknowledge and report done/err.
//
// state     | meaning
// IDLE      | ready for a command byte
// INHIBIT   | holding ps2_clk low for INHIBIT_CYCLES
// REQ       | start bit driven, clock released, waiting for fall 1
// SHIFT     | driving d0..d7, parity, stop on falls 1..10
// ACK       | waiting for fall 11 to sample the device acknowledge
// WAIT_IDLE | waiting for both lines to read high
// DONE      | one-cycle completion pulse
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic clk_s;
  logic data_s;
  logic clk_fall;
  logic data_fall_unused;  // data edge detect is consumed by the receiver only

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .clk_fall_o (clk_fall),
    .data_fall_o(data_fall_unused)
  );

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic          noack_q, noack_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  ps2_err_e      err_q, err_d;
  logic          expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      bit_q     <= '0;
      noack_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= PS2_OK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      noack_q   <= noack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    noack_d   = noack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = PS2_OK;
    expire    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d   = INHIBIT;
          cnt_d     = INHIBIT_LOAD;
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          bit_d     = '0;
          noack_d   = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      INHIBIT: begin
        if (cnt_q == '0) begin
          state_d   = REQ;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      REQ, SHIFT: begin
        if (clk_fall) begin
          state_d   = (bit_q == PS2_STOP_FALL - 4'd1) ? ACK : SHIFT;
          cnt_d     = TIMEOUT_LOAD;
          bit_d     = bit_q + 4'd1;
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[9:1]};
        end else if (cnt_q == '0) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ACK: begin
        if (clk_fall) begin
          state_d = WAIT_IDLE;
          cnt_d   = TIMEOUT_LOAD;
          bit_d   = bit_q + 4'd1;
          noack_d = data_s;
        end else if (cnt_q == '0) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = noack_q ? PS2_NOACK : PS2_OK;
        end else if (clk_fall) begin
          cnt_d = TIMEOUT_LOAD;
        end else if (cnt_q == '0) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (expire) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      err_d     = PS2_TIMEOUT;
    end
  end

  assign tx_ready    = (state_q == IDLE) && !rst;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-collector bus and a
// behavioural keyboard model that clocks the frame in and captures the bits.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int TMO  = 1000;
  localparam int HALF = 20;  // device half bit period, shortened to keep the run small

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ps2_clk_oe, ps2_data_oe;
  logic [1:0] err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pin, ps2_data_pin;

  assign ps2_clk_pin  = ~(dev_clk_low | ps2_clk_oe);
  assign ps2_data_pin = ~(dev_data_low | ps2_data_oe);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_i  (ps2_clk_pin),
    .ps2_data_i (ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Bus monitor, sampled on the falling clock edge.
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [1:0] done_err = '0;
  logic [1:0] done_oe = '0;
  int         inh_rises = 0;
  int         clk_oe_rise_cyc = 0, clk_oe_fall_cyc = 0, data_oe_rise_cyc = 0;
  logic       clk_oe_prev = 1'b0, data_oe_prev = 1'b0, start_pending = 1'b0;
  int         last_fall_cyc = 0, rel_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
      done_oe  = {ps2_clk_oe, ps2_data_oe};
    end
    if (ps2_clk_oe && !clk_oe_prev) begin
      inh_rises++;
      clk_oe_rise_cyc = cyc;
      start_pending = 1'b1;
    end
    if (!ps2_clk_oe && clk_oe_prev) clk_oe_fall_cyc = cyc;
    if (ps2_data_oe && !data_oe_prev && start_pending) begin
      data_oe_rise_cyc = cyc;
      start_pending = 1'b0;
    end
    clk_oe_prev  = ps2_clk_oe;
    data_oe_prev = ps2_data_oe;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference frame as the device sees it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, ((ones % 2) == 0), d, 1'b0};
  endfunction

  task automatic device(input int nfalls, input bit ack, input int hold,
                        output logic [10:0] bits, output bit ok);
    int n = 0;
    bits = '0;
    ok = 1'b1;
    while (!(ps2_clk_pin && !ps2_data_pin)) begin
      tick();
      n++;
      if (n > 5000) begin
        ok = 1'b0;
        return;
      end
    end
    bits[0] = ps2_data_pin;
    repeat (HALF) tick();
    for (int i = 1; i <= nfalls && i <= 10; i++) begin
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      bits[i] = ps2_data_pin;
      repeat (HALF) tick();
    end
    if (nfalls >= 11) begin
      dev_data_low = ack;
      repeat (HALF / 2) tick();
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      repeat (hold) tick();
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      rel_cyc = cyc;
      repeat (HALF) tick();
    end
  endtask

  task automatic start_tx(input logic [7:0] d, input string tag);
    check({tag, "_ready"}, int'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~d;
    check({tag, "_busy_t1"}, int'(busy), 1);
    check({tag, "_clk_oe_t1"}, int'(ps2_clk_oe), 1);
  endtask

  task automatic wait_done(input int c0, input string tag);
    int n = 0;
    while (done_cnt == c0 && n < 3 * TMO) begin
      tick();
      n++;
    end
    check({tag, "_done_count"}, done_cnt - c0, 1);
  endtask

  task automatic run_xfer(input logic [7:0] d, input int nfalls, input bit ack,
                          input int hold, input logic [1:0] exp_err, input string tag);
    logic [10:0] bits, expf, mask;
    bit ok;
    int c0, r0, exp_done;
    c0 = done_cnt;
    r0 = inh_rises;
    start_tx(d, tag);
    device(nfalls, ack, hold, bits, ok);
    check({tag, "_dev_start"}, int'(ok), 1);
    wait_done(c0, tag);
    expf = model_frame(d);
    mask = (nfalls >= 10) ? 11'h7FF : 11'((1 << (nfalls + 1)) - 1);
    // Line changes reach the FSM after 2 sync flops plus the edge/state register.
    exp_done = (nfalls < 11) ? last_fall_cyc + TMO + 3 : rel_cyc + 3;
    check({tag, "_bits"}, int'(bits & mask), int'(expf & mask));
    check({tag, "_err"}, int'(done_err), int'(exp_err));
    check({tag, "_done_time"}, done_cyc, exp_done);
    check({tag, "_oe_at_done"}, int'(done_oe), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_inhibit_len"}, clk_oe_fall_cyc - clk_oe_rise_cyc, INH);
    check({tag, "_start_with_release"}, data_oe_rise_cyc - clk_oe_fall_cyc, 0);
    check({tag, "_one_frame"}, inh_rises - r0, 1);
    tick();
  endtask

  typedef struct {
    logic [7:0] d;
    int         nfalls;
    bit         ack;
    int         hold;
    logic [1:0] exp_err;
  } vec_t;

  vec_t        vecs[6];
  logic [10:0] bits;
  bit          ok;
  int          c0, r0;

  initial begin
    repeat (150000) @(negedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hED, 11, 1'b1, 10,  PS2_OK};
    vecs[1] = '{8'hF4, 11, 1'b1, 10,  PS2_OK};
    vecs[2] = '{8'hA5, 11, 1'b0, 300, PS2_NOACK};
    vecs[3] = '{8'h00, 11, 1'b1, 1,   PS2_OK};
    vecs[4] = '{8'hFF, 11, 1'b1, 30,  PS2_OK};
    vecs[5] = '{8'h3C, 4,  1'b1, 0,   PS2_TIMEOUT};

    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx_ready", int'(tx_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", int'(tx_ready), 1);

    for (int v = 0; v < 6; v++)
      run_xfer(vecs[v].d, vecs[v].nfalls, vecs[v].ack, vecs[v].hold, vecs[v].exp_err,
               $sformatf("vec%0d", v));

    for (int r = 0; r < 6; r++) begin
      logic [7:0] d;
      bit         a;
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      run_xfer(d, 11, a, int'($urandom_range(1, 60)), a ? PS2_OK : PS2_NOACK,
               $sformatf("rand%0d", r));
    end

    // Reset in the middle of the shift phase.
    c0 = done_cnt;
    start_tx(8'hED, "rst_mid");
    device(5, 1'b0, 0, bits, ok);
    check("rst_mid_dev_start", int'(ok), 1);
    check("rst_mid_busy", int'(busy), 1);
    check("rst_mid_data_oe_before", int'(ps2_data_oe), 1);
    rst = 1'b1;
    tick();
    check("rst_mid_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_mid_data_oe", int'(ps2_data_oe), 0);
    check("rst_mid_ready_in_rst", int'(tx_ready), 0);
    rst = 1'b0;
    tick();
    check("rst_mid_ready_after", int'(tx_ready), 1);
    repeat (100) tick();
    check("rst_mid_no_done", done_cnt - c0, 0);
    run_xfer(8'hED, 11, 1'b1, 10, PS2_OK, "after_rst");

    // tx_valid pulsed while a frame is in flight must be ignored.
    c0 = done_cnt;
    r0 = inh_rises;
    start_tx(8'hF4, "busy_pulse");
    fork
      device(11, 1'b1, 10, bits, ok);
      begin
        repeat (120) tick();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (3) tick();
        tx_valid = 1'b0;
      end
    join
    wait_done(c0, "busy_pulse");
    repeat (200) tick();
    check("busy_pulse_frames", inh_rises - r0, 1);
    check("busy_pulse_dones", done_cnt - c0, 1);
    check("busy_pulse_bits", int'(bits), int'(model_frame(8'hF4)));
    check("busy_pulse_err", int'(done_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
